itype_detector_mc: RTL and testbench
====================================

Name: itype_detector_mc

Overview:
- Multi-commit-port successor of the single-port itype classifier for the CVA6 trace-encoder connector.
- Classifies every commit port each cycle into the E-trace itype code.
- Encoding width is selectable (3-bit or 4-bit), with optional call detection.
- Interrupts are latched until they are emitted.
- Classified beats pass through a parametrised FIFO with valid/ready so the encoder can stall without losing a beat.

Parameters:
- NrCommitPorts, 2, number of commit ports classified per beat (1..4).
- ItypeLen, 3, itype width in bits; legal values are 3 or 4 only (elaboration error otherwise).
- CallDetect, 1, when 1 and ItypeLen==4, emit call codes 8/9; ignored when ItypeLen==3.
- BufDepth, 2, FIFO depth in beats (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  NrCommitPorts  per-port instruction committed.
- exception_i  in  1  exception on this beat, attributed to port 0.
- interrupt_i  in  1  interrupt request pulse.
- op_i  in  NrCommitPorts x connector_pkg::fu_op  per-port functional-unit op.
- branch_taken_i  in  NrCommitPorts  per-port branch/jump taken.
- cf_type_i  in  NrCommitPorts x connector_pkg::cf_t  per-port control-flow type.
- rd_link_i  in  NrCommitPorts  per-port rd is x1/x5.
- in_ready_o  out  1  beat accepted this cycle.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  encoder consumes head.
- itype_o  out  NrCommitPorts x ItypeLen  per-port itype of head beat.
- irq_pending_o  out  1  interrupt latched, not yet emitted.

Behaviour:
- Per-port classification, first match wins, for valid ports only (exception/interrupt apply to port 0 only):
  - exception -> 1
  - interrupt -> 2
  - MRET/SRET/DRET with cf Return -> 3
  - branch op (EQ/NE/LTS/GES/LTU/GEU) with cf Branch, not taken -> 4; taken -> 5
  - JALR with cf JumpR:
    - ItypeLen==3 -> 6
    - ItypeLen==4 with CallDetect and rd_link -> 8
    - otherwise -> 10
  - cf Jump and taken:
    - ItypeLen==3 -> 0
    - ItypeLen==4 with CallDetect and rd_link -> 9
    - otherwise -> 11
  - none of the above -> 0
- Invalid ports give 0, except port 0 carrying an exception or interrupt.
- Beat suppression: when port 0 carries 1 or 2, ports 1..N-1 are forced to 0 in that beat.
- Interrupt latch:
  - irq_pend is set by interrupt_i (the pulse may be a single cycle).
  - The beat's effective interrupt is interrupt_i | irq_pend.
  - If exception_i is high in the same beat, port 0 emits 1 and irq_pend stays/becomes 1.
  - Otherwise irq_pend clears when a beat with port 0 == 2 is pushed.
  - irq_pend is held while the FIFO is full.
- Beat valid = |valid_i | exception_i | effective interrupt. A beat with all ports 0 is never pushed.
- Push condition: beat valid && in_ready_o.
- in_ready_o = !full. There is no pass-through when full; upstream must hold its inputs while in_ready_o is 0.
- Pop condition: out_valid_o && out_ready_i. Push and pop in the same cycle are allowed when not full; the count is unchanged.
- Latency: a beat pushed into an empty FIFO appears on itype_o with out_valid_o the next cycle (1 cycle). There is no combinational input->output path.
- FIFO:
  - Read/write pointers of log2(BufDepth) bits wrap modulo BufDepth.
  - Count is log2(BufDepth)+1 bits.
  - full = (count==BufDepth); empty = (count==0).
- Empty: out_valid_o=0 and itype_o driven 0, not stale data.
- Reset, including mid-operation: flushes the FIFO, clears irq_pend and pointers.
  - Outputs during and after reset: out_valid_o=0, itype_o=0, irq_pending_o=0, in_ready_o=1.

Test Plan:
- Reset, then N=2: port0 BEQ not taken, port1 BNE taken, push -> next cycle out_valid_o=1, itype_o={5,4}.
- ItypeLen=4, CallDetect=1:
  - JALR with rd_link=1 on port0 -> 8.
  - JAL taken with rd_link=0 on port1 -> 11.
  - ItypeLen=3 rebuild of the same beat -> {0,6}.
- exception_i and interrupt_i in the same cycle with port1 valid taken branch:
  - first beat -> {0,1}, irq_pending_o=1.
  - next beat with no valids -> {0,2}, then irq_pending_o=0.
- out_ready_i=0, push 2 beats (BufDepth=2) -> in_ready_o=0.
  - interrupt_i pulse while full -> irq_pending_o stays 1.
  - release out_ready_i -> beats pop in order, interrupt beat follows.
- Continuous push/pop at BufDepth=2 for 10 beats -> pointers wrap, order preserved, count stays 1.
- Assert rst_i with FIFO holding 2 beats -> out_valid_o=0, itype_o=0, in_ready_o=1 immediately (asynchronous).

Source files
------------

// File: rtl/itype_detector_mc.sv
// -----------------------------------------------------------------------------
// itype_detector_mc
//   Classifies every commit port of a retirement beat into an E-trace itype
//   code and queues the classified beat in a small FIFO so the trace encoder
//   can stall without losing a beat. A pending interrupt is held until a beat
//   carrying it on port 0 has been queued.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   valid_i             per-port committed instruction
//   exception_i         exception on this beat (port 0)
//   interrupt_i         interrupt request pulse
//   op_i                per-port functional-unit op
//   branch_taken_i      per-port branch/jump taken
//   cf_type_i           per-port control-flow type
//   rd_link_i           per-port rd is x1/x5
//   in_ready_o          FIFO can accept a beat this cycle
//   out_valid_o         FIFO head valid
//   out_ready_i         encoder consumes the head beat
//   itype_o             per-port itype of the head beat (0 when empty)
//   irq_pending_o       interrupt latched, not yet queued
// -----------------------------------------------------------------------------
package connector_pkg;
  typedef enum logic [3:0] {
    ADD, SUB, LOAD, STORE,
    EQ, NE, LTS, GES, LTU, GEU,
    JALR, MRET, SRET, DRET
  } fu_op;

  typedef enum logic [2:0] {
    NoCF, Branch, Jump, JumpR, Return
  } cf_t;
endpackage

module itype_detector_mc
  import connector_pkg::*;
#(
  parameter int NrCommitPorts = 2,
  parameter int ItypeLen      = 3,
  parameter int CallDetect    = 1,
  parameter int BufDepth      = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NrCommitPorts-1:0]                  valid_i,
  input  logic                                      exception_i,
  input  logic                                      interrupt_i,
  input  fu_op [NrCommitPorts-1:0]                  op_i,
  input  logic [NrCommitPorts-1:0]                  branch_taken_i,
  input  cf_t  [NrCommitPorts-1:0]                  cf_type_i,
  input  logic [NrCommitPorts-1:0]                  rd_link_i,
  output logic                                      in_ready_o,
  output logic                                      out_valid_o,
  input  logic                                      out_ready_i,
  output logic [NrCommitPorts-1:0][ItypeLen-1:0]    itype_o,
  output logic                                      irq_pending_o
);

  localparam int PtrW = $clog2(BufDepth);
  localparam logic [PtrW:0] FullCnt = BufDepth[PtrW:0];

  if (ItypeLen != 3 && ItypeLen != 4) begin : g_bad_itype_len
    $error("itype_detector_mc: ItypeLen must be 3 or 4");
  end
  if (NrCommitPorts < 1 || NrCommitPorts > 4) begin : g_bad_ports
    $error("itype_detector_mc: NrCommitPorts must be 1..4");
  end
  if (BufDepth < 2 || (BufDepth & (BufDepth - 1)) != 0) begin : g_bad_depth
    $error("itype_detector_mc: BufDepth must be a power of 2 and >= 2");
  end

  // Codes are computed at 4 bits and truncated to ItypeLen; the 8..11 codes
  // are only reachable when ItypeLen==4, so truncation never loses them.
  function automatic logic [3:0] f_classify(
    input logic v,
    input logic exc,
    input logic irq,
    input fu_op op,
    input logic tk,
    input cf_t  cf,
    input logic lnk
  );
    logic [3:0] c;
    logic       call;
    c    = 4'd0;
    call = (CallDetect != 0) && lnk;
    if (exc) begin
      c = 4'd1;
    end else if (irq) begin
      c = 4'd2;
    end else if (v) begin
      if ((op inside {MRET, SRET, DRET}) && cf == Return) begin
        c = 4'd3;
      end else if ((op inside {EQ, NE, LTS, GES, LTU, GEU}) && cf == Branch) begin
        c = tk ? 4'd5 : 4'd4;
      end else if (op == JALR && cf == JumpR) begin
        if (ItypeLen == 3) c = 4'd6;
        else               c = call ? 4'd8 : 4'd10;
      end else if (cf == Jump && tk) begin
        if (ItypeLen == 3) c = 4'd0;
        else               c = call ? 4'd9 : 4'd11;
      end
    end
    return c;
  endfunction

  logic                                   r_irq_pend;
  logic [NrCommitPorts-1:0][ItypeLen-1:0] r_mem [BufDepth];
  logic [PtrW-1:0]                        r_wptr;
  logic [PtrW-1:0]                        r_rptr;
  logic [PtrW:0]                          r_count;

  logic                                   w_irq_eff;
  logic [3:0]                             w_code0;
  logic [NrCommitPorts-1:0][ItypeLen-1:0] w_beat;
  logic                                   w_full;
  logic                                   w_empty;
  logic                                   w_push;
  logic                                   w_pop;

  assign w_irq_eff = interrupt_i | r_irq_pend;
  assign w_code0   = f_classify(valid_i[0], exception_i, w_irq_eff, op_i[0],
                                branch_taken_i[0], cf_type_i[0], rd_link_i[0]);

  // Ports 1..N-1 are silenced when port 0 reports an exception or interrupt.
  always_comb begin
    logic [3:0] c;
    w_beat    = '0;
    w_beat[0] = w_code0[ItypeLen-1:0];
    for (int p = 1; p < NrCommitPorts; p++) begin
      c = f_classify(valid_i[p], 1'b0, 1'b0, op_i[p],
                     branch_taken_i[p], cf_type_i[p], rd_link_i[p]);
      if (w_code0 == 4'd1 || w_code0 == 4'd2) c = 4'd0;
      w_beat[p] = c[ItypeLen-1:0];
    end
  end

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);

  // An all-zero beat carries no trace information and is dropped.
  assign w_push = (|valid_i | exception_i | w_irq_eff) && (w_beat != '0) && !w_full;
  assign w_pop  = !w_empty && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_irq_pend <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      // Stays set across an exception beat (port 0 shows 1, not 2) and
      // while the FIFO is full (no push).
      r_irq_pend <= w_irq_eff && !(w_push && w_code0 == 4'd2);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_beat;
  end

  assign in_ready_o    = !w_full;
  assign out_valid_o   = !w_empty;
  assign itype_o       = w_empty ? '0 : r_mem[r_rptr];
  assign irq_pending_o = r_irq_pend;

endmodule

// File: tb/tb_itype_detector_mc.sv
module tb_itype_detector_mc;
  import connector_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       valid;
  logic             exc;
  logic             irq;
  fu_op [1:0]       op;
  logic [1:0]       taken;
  cf_t  [1:0]       cf;
  logic [1:0]       link;
  logic             out_ready;

  logic             rdy3, ov3, irqp3;
  logic [1:0][2:0]  it3;
  logic             rdy4, ov4, irqp4;
  logic [1:0][3:0]  it4;
  logic             rdy4n, ov4n, irqp4n;
  logic [1:0][3:0]  it4n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q3[$];
  logic [7:0] q4[$];
  logic [7:0] q4n[$];

  itype_detector_mc #(.NrCommitPorts(2), .ItypeLen(3), .CallDetect(1), .BufDepth(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .exception_i(exc), .interrupt_i(irq),
    .op_i(op), .branch_taken_i(taken), .cf_type_i(cf), .rd_link_i(link),
    .in_ready_o(rdy3), .out_valid_o(ov3), .out_ready_i(out_ready),
    .itype_o(it3), .irq_pending_o(irqp3));

  itype_detector_mc #(.NrCommitPorts(2), .ItypeLen(4), .CallDetect(1), .BufDepth(2)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .exception_i(exc), .interrupt_i(irq),
    .op_i(op), .branch_taken_i(taken), .cf_type_i(cf), .rd_link_i(link),
    .in_ready_o(rdy4), .out_valid_o(ov4), .out_ready_i(out_ready),
    .itype_o(it4), .irq_pending_o(irqp4));

  itype_detector_mc #(.NrCommitPorts(2), .ItypeLen(4), .CallDetect(0), .BufDepth(2)) u_dut4n (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .exception_i(exc), .interrupt_i(irq),
    .op_i(op), .branch_taken_i(taken), .cf_type_i(cf), .rd_link_i(link),
    .in_ready_o(rdy4n), .out_valid_o(ov4n), .out_ready_i(out_ready),
    .itype_o(it4n), .irq_pending_o(irqp4n));

  logic [7:0] pk3, pk4, pk4n;
  assign pk3  = {1'b0, it3[1], 1'b0, it3[0]};
  assign pk4  = {it4[1], it4[0]};
  assign pk4n = {it4n[1], it4n[0]};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {out_valid, in_ready, irq_pending} on every instance
  task automatic chk_status(input string nm, input logic [2:0] exp);
    chk({nm, " dut3"},  {5'b0, ov3,  rdy3,  irqp3},  {5'b0, exp});
    chk({nm, " dut4"},  {5'b0, ov4,  rdy4,  irqp4},  {5'b0, exp});
    chk({nm, " dut4n"}, {5'b0, ov4n, rdy4n, irqp4n}, {5'b0, exp});
  endtask

  task automatic clr();
    valid = '0; exc = 1'b0; irq = 1'b0; taken = '0; link = '0;
    op[0] = ADD; op[1] = ADD; cf[0] = NoCF; cf[1] = NoCF;
  endtask

  task automatic port(input int p, input fu_op o, input cf_t c, input logic t, input logic l);
    valid[p] = 1'b1; op[p] = o; cf[p] = c; taken[p] = t; link[p] = l;
  endtask

  // Expected {port1, port0} for ItypeLen=3, ItypeLen=4 call, ItypeLen=4 no-call.
  task automatic expect_beat(input logic [3:0] a1, input logic [3:0] a0,
                             input logic [3:0] b1, input logic [3:0] b0,
                             input logic [3:0] c1, input logic [3:0] c0);
    q3.push_back({a1, a0});
    q4.push_back({b1, b0});
    q4n.push_back({c1, c0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare whenever an instance hands over its head beat.
  always @(negedge clk) begin
    if (!rst && ov3 && out_ready) begin
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut3 unexpected beat: got %0h expected none", pk3);
      end else chk("dut3 beat", pk3, q3.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && out_ready) begin
      if (q4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut4 unexpected beat: got %0h expected none", pk4);
      end else chk("dut4 beat", pk4, q4.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4n && out_ready) begin
      if (q4n.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut4n unexpected beat: got %0h expected none", pk4n);
      end else chk("dut4n beat", pk4n, q4n.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #3;
    chk_status("reset", 3'b010);
    chk("reset itype dut3", pk3, 8'h00);
    chk("reset itype dut4", pk4, 8'h00);
    step();
    rst = 1'b0;
    step();

    // Branch pair: BEQ not taken, BNE taken
    port(0, EQ, Branch, 1'b0, 1'b0);
    port(1, NE, Branch, 1'b1, 1'b0);
    expect_beat(5, 4, 5, 4, 5, 4);
    step(); clr();
    #3 chk_status("latency", 3'b110);

    // JALR with link on port 0, JAL taken without link on port 1
    step();
    port(0, JALR, JumpR, 1'b0, 1'b1);
    port(1, ADD, Jump, 1'b1, 1'b0);
    expect_beat(0, 6, 11, 8, 11, 10);
    step(); clr();

    // JAL taken with link on port 0, MRET return on port 1
    port(0, ADD, Jump, 1'b1, 1'b1);
    port(1, MRET, Return, 1'b0, 1'b0);
    expect_beat(3, 0, 3, 9, 3, 11);
    step(); clr();

    // All-zero beat: plain ALU op on port 0, taken branch on an invalid port 1
    port(0, ADD, NoCF, 1'b1, 1'b1);
    op[1] = NE; cf[1] = Branch; taken[1] = 1'b1;
    step(); clr();

    // SRET without Return cf gives 0; BGEU not taken on port 1
    port(0, SRET, NoCF, 1'b0, 1'b0);
    port(1, GEU, Branch, 1'b0, 1'b0);
    expect_beat(4, 0, 4, 0, 4, 0);
    step(); clr();
    repeat (2) step();

    // Exception and interrupt together; port 1 suppressed
    exc = 1'b1; irq = 1'b1;
    port(1, EQ, Branch, 1'b1, 1'b0);
    expect_beat(0, 1, 0, 1, 0, 1);
    step(); clr();
    expect_beat(0, 2, 0, 2, 0, 2);
    #3 chk_status("exc+irq", 3'b111);
    step();
    #3 chk_status("irq emitted", 3'b110);

    // Direct interrupt with a valid port 1 branch
    irq = 1'b1;
    port(1, NE, Branch, 1'b1, 1'b0);
    expect_beat(0, 2, 0, 2, 0, 2);
    step(); clr();
    #3 chk_status("irq direct", 3'b110);
    repeat (2) step();

    // Fill the FIFO with the encoder stalled
    out_ready = 1'b0;
    port(0, EQ, Branch, 1'b0, 1'b0);
    expect_beat(0, 4, 0, 4, 0, 4);
    step(); clr();
    port(1, NE, Branch, 1'b1, 1'b0);
    expect_beat(5, 0, 5, 0, 5, 0);
    step(); clr();
    #3 chk_status("full", 3'b100);
    irq = 1'b1;
    expect_beat(0, 2, 0, 2, 0, 2);
    step(); irq = 1'b0;
    #3 chk_status("irq while full", 3'b101);
    step();
    #3 chk_status("irq held", 3'b101);
    out_ready = 1'b1;
    step();
    #3 chk_status("drain1", 3'b111);
    step();
    #3 chk_status("drain2", 3'b110);
    repeat (3) step();

    // Back-to-back push/pop: occupancy stays at one beat
    for (int i = 0; i < 10; i++) begin
      clr();
      port(0, EQ, Branch, i[0], 1'b0);
      if (i[1]) port(1, MRET, Return, 1'b0, 1'b0);
      expect_beat(i[1] ? 4'd3 : 4'd0, i[0] ? 4'd5 : 4'd4,
                  i[1] ? 4'd3 : 4'd0, i[0] ? 4'd5 : 4'd4,
                  i[1] ? 4'd3 : 4'd0, i[0] ? 4'd5 : 4'd4);
      step();
      chk("stream count dut3", 8'(u_dut3.r_count), 8'd1);
      chk("stream count dut4", 8'(u_dut4.r_count), 8'd1);
      chk("stream status dut3", {6'b0, ov3, rdy3}, 8'b11);
    end
    clr();
    repeat (3) step();

    // Reset while full with an interrupt pending
    out_ready = 1'b0;
    port(0, EQ, Branch, 1'b0, 1'b0);
    expect_beat(0, 4, 0, 4, 0, 4);
    step(); clr();
    port(1, NE, Branch, 1'b1, 1'b0);
    expect_beat(5, 0, 5, 0, 5, 0);
    step(); clr();
    irq = 1'b1;
    step(); irq = 1'b0;
    #3 chk_status("pre-reset", 3'b101);
    rst = 1'b1;
    q3.delete(); q4.delete(); q4n.delete();
    #1;
    chk_status("async reset", 3'b010);
    chk("async reset itype dut3", pk3, 8'h00);
    chk("async reset itype dut4", pk4, 8'h00);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    port(0, EQ, Branch, 1'b0, 1'b0);
    port(1, NE, Branch, 1'b1, 1'b0);
    expect_beat(5, 4, 5, 4, 5, 4);
    step(); clr();
    repeat (4) step();

    chk("dut3 queue drained",  8'(q3.size()),  8'd0);
    chk("dut4 queue drained",  8'(q4.size()),  8'd0);
    chk("dut4n queue drained", 8'(q4n.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
